// File: rtl/aurora_tx_crc_scheduler.sv
// Two-requester frame scheduler feeding an Aurora TX stream: payload pass-through, optional
// even-length padding, then a CRC trailer word taken from an external fixed-latency CRC16 engine.
module aurora_tx_crc_scheduler #(
  parameter int PAD_ODD = 1,
  parameter int CRC_LAT = 2
) (
  input  logic        s_axis_aclk,
  input  logic        aresetn,
  input  logic [31:0] s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  output logic        s0_axis_tready,
  input  logic [31:0] s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  output logic        s1_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        crc_reset,
  output logic        crc_datavalid,
  output logic [31:0] crc_data,
  input  logic [15:0] crc_in,
  output logic [1:0]  grant,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, CRC_WAIT, CRC} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(CRC_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_grant;
  logic [1:0]  r_last;
  logic        r_parity;
  logic [3:0]  r_cnt;
  logic [15:0] r_crc;
  logic [15:0] r_frames;

  logic [1:0]  w_arb;
  logic [31:0] w_s_dat;
  logic        w_s_vld;
  logic        w_s_lst;
  logic        w_beat;

  assign w_s_dat = r_grant[1] ? s1_axis_tdata  : s0_axis_tdata;
  assign w_s_vld = r_grant[1] ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_s_lst = r_grant[1] ? s1_axis_tlast  : s0_axis_tlast;
  assign w_beat  = (r_state == DATA) && w_s_vld && m_axis_tready;

  assign grant       = r_grant;
  assign frames_sent = r_frames;

  // Contention goes to whoever did not own the previous frame.
  always_comb begin
    w_arb = 2'b00;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      w_arb = r_last[0] ? 2'b10 : 2'b01;
    end else if (s0_axis_tvalid) begin
      w_arb = 2'b01;
    end else if (s1_axis_tvalid) begin
      w_arb = 2'b10;
    end
  end

  always_comb begin
    w_next         = r_state;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tdata   = 32'h0;
    m_axis_tkeep   = 4'h0;
    m_axis_tlast   = 1'b0;
    m_axis_tvalid  = 1'b0;
    crc_reset      = 1'b0;
    crc_datavalid  = 1'b0;
    crc_data       = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_arb != 2'b00) begin
          w_next    = DATA;
          crc_reset = aresetn;
        end
      end
      DATA: begin
        m_axis_tvalid  = w_s_vld;
        m_axis_tdata   = w_s_dat;
        m_axis_tkeep   = 4'hF;
        s0_axis_tready = r_grant[0] & m_axis_tready;
        s1_axis_tready = r_grant[1] & m_axis_tready;
        if (w_beat) begin
          crc_datavalid = 1'b1;
          crc_data      = w_s_dat;
          // parity still reflects the words before this one
          if (w_s_lst) begin
            w_next = ((PAD_ODD != 0) && !r_parity) ? PAD : CRC_WAIT;
          end
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 4'hF;
        if (m_axis_tready) begin
          crc_datavalid = 1'b1;
          w_next        = CRC_WAIT;
        end
      end
      CRC_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = CRC;
        end
      end
      CRC: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {r_crc, 16'h0000};
        m_axis_tkeep  = 4'hC;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_grant  <= 2'b00;
      r_last   <= 2'b10;
      r_parity <= 1'b0;
      r_cnt    <= 4'd0;
      r_crc    <= 16'h0;
      r_frames <= 16'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_parity <= 1'b0;
          if (w_next == DATA) begin
            r_grant <= w_arb;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_parity <= ~r_parity;
            if (w_s_lst) begin
              r_cnt <= LP_CNT_INIT;
            end
          end
        end
        PAD: begin
          if (m_axis_tready) begin
            r_cnt <= LP_CNT_INIT;
          end
        end
        CRC_WAIT: begin
          // Engine result is valid exactly now; capture it so the trailer holds through stalls.
          if (r_cnt == 4'd0) begin
            r_crc <= crc_in;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        CRC: begin
          if (m_axis_tready) begin
            r_frames <= r_frames + 16'd1;
            r_last   <= r_grant;
            r_grant  <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_crc_scheduler.sv
// Randomised bench for aurora_tx_crc_scheduler with a frame-level scoreboard and a CRC engine model.
module tb_aurora_tx_crc_scheduler;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] src_dat[2];
  logic        src_vld[2];
  logic        src_lst[2];
  logic        s0_rdy, s1_rdy;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic        crc_reset, crc_datavalid;
  logic [31:0] crc_data;
  logic [15:0] crc_in;
  logic [1:0]  grant;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  aurora_tx_crc_scheduler #(.PAD_ODD(1), .CRC_LAT(LAT)) dut (
    .s_axis_aclk(clk), .aresetn(aresetn),
    .s0_axis_tdata(src_dat[0]), .s0_axis_tvalid(src_vld[0]), .s0_axis_tlast(src_lst[0]),
    .s0_axis_tready(s0_rdy),
    .s1_axis_tdata(src_dat[1]), .s1_axis_tvalid(src_vld[1]), .s1_axis_tlast(src_lst[1]),
    .s1_axis_tready(s1_rdy),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .crc_reset(crc_reset), .crc_datavalid(crc_datavalid), .crc_data(crc_data),
    .crc_in(crc_in), .grant(grant), .frames_sent(frames_sent)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r = c;
    logic fb;
    for (int i = 31; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // External CRC engine: result settles LAT cycles after the last data strobe, junk before that.
  logic [15:0] eng_acc, eng_junk;
  int          eng_age;
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      eng_acc  <= 16'h0;
      eng_junk <= 16'h0;
      eng_age  <= 0;
    end else begin
      eng_junk <= 16'($urandom);
      if (crc_reset) begin
        eng_acc <= 16'hFFFF;
        eng_age <= 0;
      end else if (crc_datavalid) begin
        eng_acc <= crc_step(eng_acc, crc_data);
        eng_age <= 0;
      end else if (eng_age < 100) begin
        eng_age <= eng_age + 1;
      end
    end
  end
  assign crc_in = (eng_age >= LAT - 1) ? eng_acc : eng_junk;

  int rdy_mode = 0;
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model state
  int          exp_len0[$], exp_len1[$];
  logic [31:0] exp_w0[$], exp_w1[$];
  logic [36:0] obs_q[$];
  int  last_g = 1;
  int  tb_frames = 0;
  int  dv_cnt = 0, rst_cnt = 0;
  int  viol_crc = 0, viol_rdy = 0, viol_stall = 0;
  int  cyc = 0, last_hs = 0;
  bit  mon_en = 1'b1;
  bit  pend_g = 1'b0;
  logic [1:0]  exp_g;
  bit          prev_stall = 1'b0, prev_vld = 1'b0;
  logic [36:0] prev_beat;

  task automatic check_frame(input int g);
    int n;
    logic [31:0] w;
    logic [15:0] c;
    logic [36:0] e[$];
    if ((g == 0 && exp_len0.size() == 0) || (g == 1 && exp_len1.size() == 0)) begin
      chk("unexpected_frame", 1, 0);
      obs_q.delete();
      return;
    end
    n = (g == 0) ? exp_len0.pop_front() : exp_len1.pop_front();
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      w = (g == 0) ? exp_w0.pop_front() : exp_w1.pop_front();
      c = crc_step(c, w);
      e.push_back({w, 4'hF, 1'b0});
    end
    if (n % 2 == 1) begin
      c = crc_step(c, 32'h0);
      e.push_back({32'h0, 4'hF, 1'b0});
    end
    e.push_back({c, 16'h0, 4'hC, 1'b1});
    chk("frame_beats", obs_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < obs_q.size()) chk("beat", obs_q[i], e[i]);
    chk("crc_dv_count", dv_cnt, n + n % 2);
    chk("crc_reset_count", rst_cnt, 1);
    dv_cnt = 0;
    rst_cnt = 0;
    obs_q.delete();
    tb_frames++;
    last_g = g;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!aresetn || !mon_en) begin
      prev_stall = 1'b0;
      prev_vld   = 1'b0;
    end else begin
      if (pend_g) begin
        chk("grant", grant, exp_g);
        pend_g = 1'b0;
      end
      if (crc_reset) begin
        chk("grant_idle", grant, 2'b00);
        if (src_vld[0] && src_vld[1]) exp_g = (last_g == 1) ? 2'b01 : 2'b10;
        else if (src_vld[0])           exp_g = 2'b01;
        else                           exp_g = 2'b10;
        pend_g = 1'b1;
        rst_cnt++;
      end
      if (crc_datavalid) begin
        dv_cnt++;
        if (!(m_tvalid && m_tready) || crc_data != m_tdata || m_tlast) viol_crc++;
      end else if (crc_data != 32'h0) begin
        viol_crc++;
      end
      if ((grant != 2'b01 && s0_rdy) || (grant != 2'b10 && s1_rdy)) viol_rdy++;
      if (prev_stall && (!m_tvalid || {m_tdata, m_tkeep, m_tlast} != prev_beat)) viol_stall++;
      if (m_tvalid && m_tlast && !prev_vld) chk("crc_gap", cyc - last_hs - 1, LAT);
      if (m_tvalid && m_tready) begin
        obs_q.push_back({m_tdata, m_tkeep, m_tlast});
        last_hs = cyc;
        if (m_tlast) check_frame(grant == 2'b10 ? 1 : 0);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_vld   = m_tvalid;
      prev_beat  = {m_tdata, m_tkeep, m_tlast};
    end
  end

  task automatic send_frame(input int s, input int len, input logic [31:0] seed, input int gap_max);
    logic [31:0] w;
    bit hs;
    int waited;
    if (s == 0) exp_len0.push_back(len); else exp_len1.push_back(len);
    for (int i = 0; i < len; i++) begin
      w = seed + 32'(i) * 32'h11111111;
      if (s == 0) exp_w0.push_back(w); else exp_w1.push_back(w);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          src_vld[s] = 1'b0;
          @(posedge clk); #1;
        end
      end
      src_vld[s] = 1'b1;
      src_dat[s] = w;
      src_lst[s] = (i == len - 1);
      hs = 1'b0;
      waited = 0;
      while (!hs && waited < 1000) begin
        @(negedge clk);
        hs = (s == 0) ? s0_rdy : s1_rdy;
        @(posedge clk); #1;
        waited++;
      end
      if (!hs) chk("handshake_timeout", 0, 1);
    end
    src_vld[s] = 1'b0;
    src_lst[s] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      done = (exp_len0.size() == 0 && exp_len1.size() == 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_s0_tready"}, s0_rdy, 0);
    chk({p, "_s1_tready"}, s1_rdy, 0);
    chk({p, "_tvalid"}, m_tvalid, 0);
    chk({p, "_tlast"}, m_tlast, 0);
    chk({p, "_tkeep"}, m_tkeep, 0);
    chk({p, "_crc_reset"}, crc_reset, 0);
    chk({p, "_crc_dv"}, crc_datavalid, 0);
    chk({p, "_crc_data"}, crc_data, 0);
    chk({p, "_grant"}, grant, 0);
    chk({p, "_frames"}, frames_sent, 0);
  endtask

  initial begin
    bit hs;
    aresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_dat[i] = 32'hDEAD0000 + 32'(i);
      src_vld[i] = 1'b1;
      src_lst[i] = 1'b0;
    end
    #12;
    reset_checks("reset");
    src_vld[0] = 1'b0;
    src_vld[1] = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Two-word frame, no pad
    send_frame(0, 2, 32'h11111111, 0);
    wait_drain();
    chk("frames_after_first", frames_sent, 1);

    // Three-word frame gets a pad word
    send_frame(0, 3, 32'h11111111, 0);
    wait_drain();

    // Both requesters continuously offering single-word frames
    fork
      repeat (4) send_frame(0, 1, $urandom, 0);
      repeat (4) send_frame(1, 1, $urandom, 0);
    join
    wait_drain();

    // Alternating sink backpressure across a four-word frame
    rdy_mode = 1;
    send_frame(1, 4, $urandom, 0);
    wait_drain();

    rdy_mode = 2;
    fork
      repeat (12) send_frame(0, $urandom_range(1, 8), $urandom, 2);
      repeat (12) send_frame(1, $urandom_range(1, 8), $urandom, 2);
    join
    wait_drain();
    chk("frames_sent", frames_sent, 16'(tb_frames));
    chk("crc_strobe_violations", viol_crc, 0);
    chk("tready_violations", viol_rdy, 0);
    chk("stall_violations", viol_stall, 0);

    // Reset during the second word of a frame
    mon_en = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    src_vld[0] = 1'b1;
    src_dat[0] = 32'hA5A50001;
    src_lst[0] = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = s0_rdy;
      @(posedge clk); #1;
    end
    if (!hs) chk("abort_handshake_timeout", 0, 1);
    src_dat[0] = 32'hA5A50002;
    #2;
    aresetn = 1'b0;
    #1;
    reset_checks("abort");
    src_vld[0] = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    obs_q.delete();
    exp_len0.delete(); exp_len1.delete();
    exp_w0.delete();   exp_w1.delete();
    dv_cnt = 0; rst_cnt = 0; last_g = 1; pend_g = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_frame(1, 3, $urandom, 0);
    wait_drain();
    chk("frames_after_abort", frames_sent, 1);
    chk("final_violations", viol_crc + viol_rdy + viol_stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
